// File: rtl/muldiv.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, driven by a start/busy/done handshake.
module muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  kill,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [2:0]      op;      // latched funct3
    logic            neg;     // sign to apply to the final result
    logic [W-1:0]    opnd;    // multiplicand magnitude, or divisor magnitude
    logic [2*W-1:0]  acc;     // mul: {partial sum, multiplier}; div: {remainder, dividend/quotient}

    logic            accept, last;
    logic            s1, s2, n1, n2;
    logic [W-1:0]    m1, m2;
    logic            div_zero, div_ovf, special;
    logic [W-1:0]    spec_val;

    logic [W:0]      mul_sum;
    logic [W:0]      rem_sh;
    logic            ge;
    logic [W-1:0]    diff;
    logic [2*W-1:0]  acc_nxt;
    logic [2*W-1:0]  prod_s;
    logic [W-1:0]    quo_s, rem_s, fin;

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (cnt == CW'(W - 1));
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

    // Operand decode at accept: sign extraction, magnitudes and the
    // divide special cases that complete without iterating.
    always_comb begin
        s1       = funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
        s2       = funct3 inside {3'b001, 3'b100, 3'b110};
        n1       = s1 & op1[W-1];
        n2       = s2 & op2[W-1];
        m1       = n1 ? -op1 : op1;
        m2       = n2 ? -op2 : op2;
        div_zero = funct3[2] && (op2 == '0);
        div_ovf  = (funct3 == 3'b100 || funct3 == 3'b110) &&
                   (op1 == {1'b1, {(W-1){1'b0}}}) && (&op2);
        special  = div_zero | div_ovf;
        if (div_zero)
            spec_val = funct3[1] ? op1 : '1;
        else
            spec_val = funct3[1] ? '0 : op1;
    end

    // One iteration step plus the sign-corrected result of the final step.
    always_comb begin
        mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_sh  = acc[2*W-1:W-1];
        ge      = (rem_sh >= {1'b0, opnd});
        // When ge holds the true difference is below 2^W, so W bits suffice.
        diff    = rem_sh[W-1:0] - opnd;
        if (op[2])
            acc_nxt = {(ge ? diff : rem_sh[W-1:0]), acc[W-2:0], ge};
        else
            acc_nxt = {mul_sum, acc[W-1:1]};

        prod_s = neg ? -acc_nxt : acc_nxt;
        quo_s  = neg ? -acc_nxt[W-1:0] : acc_nxt[W-1:0];
        rem_s  = neg ? -acc_nxt[2*W-1:W] : acc_nxt[2*W-1:W];
        case (op)
            3'b000:                 fin = prod_s[W-1:0];
            3'b001, 3'b010, 3'b011: fin = prod_s[2*W-1:W];
            3'b100, 3'b101:         fin = quo_s;
            default:                fin = rem_s;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: kill aborts everything, special cases skip CALC.
    always_comb begin
        state_nxt = state;
        if (kill) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) state_nxt = special ? DONE : CALC;
                    else        state_nxt = IDLE;
                end
                CALC:    if (last) state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: load at accept, iterate in CALC, register result on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            op     <= '0;
            neg    <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            result <= '0;
        end else if (kill) begin
            cnt    <= '0;
        end else if (accept) begin
            cnt <= '0;
            op  <= funct3;
            neg <= (funct3 == 3'b110) ? n1 : (n1 ^ n2);
            if (funct3[2]) begin
                opnd <= m2;
                acc  <= {{W{1'b0}}, m1};
            end else begin
                opnd <= m1;
                acc  <= {{W{1'b0}}, m2};
            end
            if (special) result <= spec_val;
        end else if (state == CALC) begin
            acc <= acc_nxt;
            cnt <= cnt + CW'(1);
            if (last) result <= fin;
        end
    end

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: scoreboard of expected results,
// handshake timing, special cases, abort/reset and back-to-back issue.
module tb_muldiv;

    logic        clk = 1'b0;
    logic        rst, start, kill;
    logic [2:0]  funct3;
    logic [31:0] op1, op2;
    logic        busy, done;
    logic [31:0] result;

    int total_cnt = 0;
    int pass_cnt  = 0;
    logic [31:0] exp_q[$];

    muldiv #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .kill(kill), .funct3(funct3),
        .op1(op1), .op2(op2), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        up;
        logic signed [31:0] qa, qb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        qa = a;
        qb = b;
        up = {32'b0, a} * {32'b0, b};
        case (f)
            3'd0: return up[31:0];
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * $signed({32'b0, b}); return sp[63:32]; end
            3'd3: return up[63:32];
            3'd4: if (b == 0) return 32'hFFFFFFFF;
                  else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
                  else return qa / qb;
            3'd5: if (b == 0) return 32'hFFFFFFFF; else return a / b;
            3'd6: if (b == 0) return a;
                  else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                  else return qa % qb;
            default: if (b == 0) return a; else return a % b;
        endcase
    endfunction

    function automatic bit ref_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    endfunction

    // Issue one op, scramble the inputs after accept, wait for done.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output bit tmo);
        @(negedge clk);
        start = 1'b1; funct3 = f; op1 = a; op2 = b;
        @(posedge clk);
        #1;
        start = 1'b0; op1 = $urandom; op2 = $urandom; funct3 = 3'($urandom_range(0, 7));
        lat = 0;
        tmo = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) begin tmo = 1'b0; break; end
            lat++;
        end
        res = result;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'd0; op1 = '0; op2 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b exp 0", done); else pass_cnt++;
        total_cnt++; if (result !== 32'h0) $display("FAIL reset_result: got %h exp 0", result); else pass_cnt++;
    endtask

    task automatic test_mul();
        int first_done, ndone;
        bit busy_ok;
        logic [31:0] res, exp;
        exp_q.push_back(32'hFFFFFFEB);
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; op1 = 32'd7; op2 = 32'hFFFFFFFD;
        @(posedge clk);
        #1 start = 1'b0; op1 = $urandom; op2 = $urandom;
        first_done = -1; ndone = 0; busy_ok = 1'b1; res = 'x;
        for (int e = 0; e <= 36; e++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first_done < 0) begin first_done = e; res = result; end
            end
            if (e <= 32 && busy !== 1'b1) busy_ok = 1'b0;
            if (e >= 33 && busy !== 1'b0) busy_ok = 1'b0;
        end
        exp = exp_q.pop_front();
        total_cnt++; if (res !== exp) $display("FAIL mul_result: got %h exp %h", res, exp); else pass_cnt++;
        total_cnt++; if (first_done != 32) $display("FAIL mul_done_edge: got %0d exp 32", first_done); else pass_cnt++;
        total_cnt++; if (ndone != 1) $display("FAIL mul_done_count: got %0d exp 1", ndone); else pass_cnt++;
        total_cnt++; if (!busy_ok) $display("FAIL mul_busy_window: got bad exp busy edges 0..32"); else pass_cnt++;
    endtask

    // Fixed-vector ops from the plan: {funct3, op1, op2, expected, special}.
    task automatic test_vectors();
        logic [2:0]  vf[12]  = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd0};
        logic [31:0] va[12]  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                 32'd7, 32'd7, 32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd3};
        logic [31:0] vb[12]  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2, 32'd2,
                                 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd4};
        logic [31:0] ve[12]  = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                 32'd3, 32'd1, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'd12};
        bit          vs[12]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
        logic [31:0] res, exp;
        int lat, elat;
        bit tmo;
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(ve[i]);
            run_op(vf[i], va[i], vb[i], res, lat, tmo);
            exp  = exp_q.pop_front();
            elat = vs[i] ? 0 : 32;
            total_cnt++;
            if (tmo || res !== exp) $display("FAIL vec%0d_result: got %h exp %h (timeout=%0d)", i, res, exp, tmo);
            else pass_cnt++;
            total_cnt++;
            if (lat != elat) $display("FAIL vec%0d_latency: got %0d exp %0d", i, lat, elat); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, exp;
        logic [2:0]  f;
        int lat, elat;
        bit tmo;
        for (int i = 0; i < 16; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if (i % 5 == 1) b = b >> $urandom_range(16, 31);
            if (i % 7 == 3) b = 32'h0;
            if (i == 9) begin f = 3'd6; a = 32'h80000000; b = 32'hFFFFFFFF; end
            exp_q.push_back(ref_result(f, a, b));
            elat = ref_special(f, a, b) ? 0 : 32;
            run_op(f, a, b, res, lat, tmo);
            exp = exp_q.pop_front();
            total_cnt++;
            if (tmo || res !== exp) $display("FAIL rand%0d f=%0d a=%h b=%h: got %h exp %h", i, f, a, b, res, exp);
            else pass_cnt++;
            total_cnt++;
            if (lat != elat) $display("FAIL rand%0d_latency: got %0d exp %0d", i, lat, elat); else pass_cnt++;
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] res, exp;
        int lat, ndone;
        bit tmo;
        exp_q.push_back(32'd30);
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; op1 = 32'd5; op2 = 32'd6;
        @(posedge clk);
        #1 op1 = 32'd9; op2 = 32'd9;
        lat = 0; tmo = 1'b1; ndone = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 10) start = 1'b0;
            if (done) begin tmo = 1'b0; break; end
            lat++;
        end
        res = result;
        exp = exp_q.pop_front();
        total_cnt++; if (tmo || res !== exp) $display("FAIL ignore_start_result: got %h exp %h", res, exp); else pass_cnt++;
        total_cnt++; if (lat != 32) $display("FAIL ignore_start_latency: got %0d exp 32", lat); else pass_cnt++;
        repeat (5) begin @(negedge clk); if (done) ndone++; end
        total_cnt++; if (ndone != 0 || busy !== 1'b0) $display("FAIL ignore_start_extra: got done=%0d busy=%b exp 0", ndone, busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res2, exp;
        int lat1, lat2, npulse;
        bit tmo, seen;
        exp_q.push_back(32'd14);
        exp_q.push_back(32'd0);
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; op1 = 32'd100; op2 = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        lat1 = 0; tmo = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) begin tmo = 1'b0; break; end
            lat1++;
        end
        exp = exp_q.pop_front();
        total_cnt++; if (tmo || result !== exp) $display("FAIL b2b_first_result: got %h exp %h", result, exp); else pass_cnt++;
        total_cnt++; if (lat1 != 32) $display("FAIL b2b_first_latency: got %0d exp 32", lat1); else pass_cnt++;
        start = 1'b1; funct3 = 3'd3; op1 = 32'd2; op2 = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 1'b0; npulse = 0; lat2 = -1; res2 = 'x;
        for (int e = 0; e <= 40; e++) begin
            @(negedge clk);
            if (e == 0) begin
                total_cnt++; if (done !== 1'b0) $display("FAIL b2b_done_drop: got %b exp 0", done); else pass_cnt++;
                total_cnt++; if (result !== 32'd14) $display("FAIL b2b_result_hold: got %h exp %h", result, 32'd14); else pass_cnt++;
            end
            if (done) begin
                npulse++;
                if (!seen) begin seen = 1'b1; lat2 = e; res2 = result; end
            end
        end
        exp = exp_q.pop_front();
        total_cnt++; if (res2 !== exp) $display("FAIL b2b_second_result: got %h exp %h", res2, exp); else pass_cnt++;
        total_cnt++; if (lat2 != 32) $display("FAIL b2b_second_latency: got %0d exp 32", lat2); else pass_cnt++;
        total_cnt++; if (npulse != 1) $display("FAIL b2b_pulse_count: got %0d exp 1", npulse); else pass_cnt++;
    endtask

    task automatic test_kill();
        logic [31:0] res, exp;
        int lat, ndone;
        bit tmo;
        exp_q.push_back(32'd12);
        run_op(3'd0, 32'd3, 32'd4, res, lat, tmo);
        exp = exp_q.pop_front();
        total_cnt++; if (tmo || res !== exp) $display("FAIL kill_setup_result: got %h exp %h", res, exp); else pass_cnt++;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd3; op1 = 32'hFFFFFFFF; op2 = 32'hFFFFFFFF;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL kill_busy: got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (result !== 32'd12) $display("FAIL kill_result: got %h exp %h", result, 32'd12); else pass_cnt++;
        ndone = 0;
        repeat (40) begin if (done) ndone++; @(negedge clk); end
        total_cnt++; if (ndone != 0) $display("FAIL kill_no_done: got %0d exp 0", ndone); else pass_cnt++;
    endtask

    task automatic test_rst();
        int ndone;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd1; op1 = 32'h12345678; op2 = 32'h9ABCDEF0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL rst_done: got %b exp 0", done); else pass_cnt++;
        total_cnt++; if (result !== 32'h0) $display("FAIL rst_result: got %h exp 0", result); else pass_cnt++;
        ndone = 0;
        repeat (40) begin @(negedge clk); if (done) ndone++; end
        total_cnt++; if (ndone != 0) $display("FAIL rst_no_done: got %0d exp 0", ndone); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_vectors();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_kill();
        test_rst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
